// File: rtl/dpd_adapt_ctrl_pkg.sv
// Shared types for the DPD adaptation controller slice.
// Optional watchdog in the controller is built when DPD_ADAPT_CTRL_WDT_EN is defined.
package package_dpd;

   typedef logic [15:0] u16;
   typedef logic [19:0] u20;
   typedef logic [31:0] u32;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_CAPTURE,
      ST_HOLD,
      ST_FAULT
   } dpd_ctrl_st_t;

   localparam u16 U16_MAX = 16'hFFFF;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic u16 sat_inc16(input u16 v);
      return (v == U16_MAX) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/dpd_adapt_ctrl_act_meter.sv
// Activity meter: counts capture-window samples whose magnitude reaches the
// threshold and flags whether the count reaches MIN_ACT.
// act_ok looks at the count including the sample being taken this cycle, so a
// decision taken on the last capture edge already sees the final sample.
module dpd_act_meter
   import package_dpd::*;
#(
   parameter u32 MIN_ACT = 32'd400
)
(
   input  logic clk,
   input  logic reset_b,
   input  logic clr,
   input  logic en,
   input  u20   magn,
   input  u20   thr,
   output u16   act_cnt,
   output logic act_ok
);

   u16 act_nxt;

   // Next count: clear on window entry, saturating increment per active sample.
   always_comb begin
      act_nxt = act_cnt;
      if (clr)
         act_nxt = '0;
      else if (en && (magn >= thr))
         act_nxt = sat_inc16(act_cnt);
   end

   assign act_ok = (u32'(act_nxt) >= MIN_ACT);

   // Count register.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b)
         act_cnt <= '0;
      else
         act_cnt <= act_nxt;
   end

endmodule

// File: rtl/dpd_adapt_ctrl.sv
// DPD adaptation controller: sequences settle / capture / hold phases, drives
// the dpd_adapt window strobe and reports per-iteration acceptance.
// Define DPD_ADAPT_CTRL_WDT_EN to build the consecutive-failure watchdog
// (FAULT state, fail_cnt); otherwise fault is tied low.
module dpd_adapt_ctrl
   import package_dpd::*;
#(
   parameter u32 SETTLE   = 32'd540,
   parameter u32 WINDOW   = 32'd800,
   parameter u32 UPDATE   = 32'd64,
   parameter u32 MIN_ACT  = 32'd400,
   parameter u32 MAX_FAIL = 32'd4
)
(
   input  logic clk,
   input  logic reset_b,
   input  logic enable,
   input  logic start,
   input  logic cont,
   input  u20   magn,
   input  u20   mag_thr,
   output logic dpd_adapt,
   output logic busy,
   output logic done,
   output logic valid,
   output u16   iter_cnt,
   output logic fault
);

   localparam u16 SETTLE_LD = u16'(SETTLE - 32'd1);
   localparam u16 WINDOW_LD = u16'(WINDOW - 32'd1);
   localparam u16 UPDATE_LD = u16'(UPDATE - 32'd1);

   dpd_ctrl_st_t st;
   u16           cnt;
   logic         meter_clr;
   logic         meter_en;
   logic         act_ok;
   logic         fin;
   // Activity count kept observable on the meter; the FSM only needs act_ok.
   u16           act_cnt_unused;

`ifdef DPD_ADAPT_CTRL_WDT_EN
   u16           fail_cnt;
`else
   assign fault = 1'b0;
`endif

   assign meter_clr = enable && (st == ST_SETTLE) && (cnt == '0);
   assign meter_en  = (st == ST_CAPTURE);

   // Outputs are registered, so the iteration result is taken on the edge that
   // enters the last HOLD cycle; with a one-cycle HOLD that is the last CAPTURE edge.
   assign fin = enable &&
                (((st == ST_CAPTURE) && (cnt == '0) && (UPDATE == 32'd1)) ||
                 ((st == ST_HOLD) && (cnt == 16'd1)));

   dpd_act_meter #(
      .MIN_ACT (MIN_ACT)
   ) u_meter (
      .clk     (clk),
      .reset_b (reset_b),
      .clr     (meter_clr),
      .en      (meter_en),
      .magn    (magn),
      .thr     (mag_thr),
      .act_cnt (act_cnt_unused),
      .act_ok  (act_ok)
   );

   // Phase sequencer with registered strobes and iteration bookkeeping.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         st        <= ST_IDLE;
         cnt       <= '0;
         dpd_adapt <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         valid     <= 1'b0;
         iter_cnt  <= '0;
`ifdef DPD_ADAPT_CTRL_WDT_EN
         fault     <= 1'b0;
         fail_cnt  <= '0;
`endif
      end else begin
         dpd_adapt <= 1'b0;
         busy      <= 1'b0;
         if (!enable) begin
            st  <= ST_IDLE;
            cnt <= '0;
`ifdef DPD_ADAPT_CTRL_WDT_EN
            if (st == ST_FAULT) begin
               fault    <= 1'b0;
               fail_cnt <= '0;
            end
`endif
         end else begin
            case (st)
               ST_IDLE: begin
                  if (start || cont) begin
                     st   <= ST_SETTLE;
                     cnt  <= SETTLE_LD;
                     busy <= 1'b1;
                  end
               end
               ST_SETTLE: begin
                  busy <= 1'b1;
                  if (cnt == '0) begin
                     st        <= ST_CAPTURE;
                     cnt       <= WINDOW_LD;
                     dpd_adapt <= 1'b1;
                  end else begin
                     cnt <= cnt - 16'd1;
                  end
               end
               ST_CAPTURE: begin
                  busy <= 1'b1;
                  if (cnt == '0) begin
                     st  <= ST_HOLD;
                     cnt <= UPDATE_LD;
                  end else begin
                     cnt       <= cnt - 16'd1;
                     dpd_adapt <= 1'b1;
                  end
               end
               ST_HOLD: begin
                  if (cnt != '0) begin
                     busy <= 1'b1;
                     cnt  <= cnt - 16'd1;
                  end
`ifdef DPD_ADAPT_CTRL_WDT_EN
                  else if (u32'(fail_cnt) >= MAX_FAIL) begin
                     st    <= ST_FAULT;
                     fault <= 1'b1;
                  end
`endif
                  else if (cont) begin
                     st   <= ST_SETTLE;
                     cnt  <= SETTLE_LD;
                     busy <= 1'b1;
                  end else begin
                     st <= ST_IDLE;
                  end
               end
               ST_FAULT: begin
               end
               default: st <= ST_IDLE;
            endcase
         end

         done <= fin;
         if (fin) begin
            valid <= act_ok;
            if (act_ok)
               iter_cnt <= iter_cnt + 16'd1;
`ifdef DPD_ADAPT_CTRL_WDT_EN
            fail_cnt <= act_ok ? '0 : sat_inc16(fail_cnt);
`endif
         end
      end
   end

endmodule

// File: tb/tb_dpd_adapt_ctrl.sv
// Self-checking bench for dpd_adapt_ctrl (SETTLE=4, WINDOW=8, UPDATE=3,
// MIN_ACT=5, MAX_FAIL=2). Watchdog scenario is active with DPD_ADAPT_CTRL_WDT_EN.
`timescale 1ns/1ps
module tb_dpd_adapt_ctrl;

   localparam int unsigned P_SETTLE   = 4;
   localparam int unsigned P_WINDOW   = 8;
   localparam int unsigned P_UPDATE   = 3;
   localparam int unsigned P_MIN_ACT  = 5;
   localparam int unsigned P_MAX_FAIL = 2;
   localparam int unsigned TOTAL      = P_SETTLE + P_WINDOW + P_UPDATE;
   localparam logic [19:0] HI  = 20'd1000;
   localparam logic [19:0] LO  = 20'd10;
   localparam logic [19:0] THR = 20'd100;
`ifdef DPD_ADAPT_CTRL_WDT_EN
   localparam bit WDT = 1'b1;
`else
   localparam bit WDT = 1'b0;
`endif

   logic        clk     = 1'b0;
   logic        reset_b = 1'b0;
   logic        enable  = 1'b0;
   logic        start   = 1'b0;
   logic        cont    = 1'b0;
   logic [19:0] magn    = '0;
   logic [19:0] mag_thr = '0;
   logic        dpd_adapt, busy, done, valid, fault;
   logic [15:0] iter_cnt;

   int unsigned total = 0;
   int unsigned bad   = 0;
   bit          chk_on = 1'b0;

   always #5 clk = ~clk;

   dpd_adapt_ctrl #(
      .SETTLE   (P_SETTLE),
      .WINDOW   (P_WINDOW),
      .UPDATE   (P_UPDATE),
      .MIN_ACT  (P_MIN_ACT),
      .MAX_FAIL (P_MAX_FAIL)
   ) dut (
      .clk       (clk),
      .reset_b   (reset_b),
      .enable    (enable),
      .start     (start),
      .cont      (cont),
      .magn      (magn),
      .mag_thr   (mag_thr),
      .dpd_adapt (dpd_adapt),
      .busy      (busy),
      .done      (done),
      .valid     (valid),
      .iter_cnt  (iter_cnt),
      .fault     (fault)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: pos is the 1-based cycle index inside the running
   // iteration (0 = not running); iteration length is SETTLE+WINDOW+UPDATE.
   int unsigned pos = 0, hits = 0, m_iter = 0, m_fail = 0;
   bit          m_valid = 1'b0, m_fault = 1'b0;

   always @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         pos = 0; hits = 0; m_iter = 0; m_fail = 0; m_valid = 1'b0; m_fault = 1'b0;
      end else if (m_fault) begin
         if (!enable) begin m_fault = 1'b0; m_fail = 0; end
      end else if (!enable) begin
         pos = 0;
      end else if (pos == 0) begin
         if (start || cont) pos = 1;
      end else if (pos == TOTAL) begin
         if (WDT && m_fail >= P_MAX_FAIL) begin m_fault = 1'b1; pos = 0; end
         else pos = cont ? 1 : 0;
      end else begin
         if (pos > P_SETTLE && pos <= P_SETTLE + P_WINDOW && magn >= mag_thr && hits < 65535)
            hits++;
         pos++;
         if (pos == P_SETTLE + 1) hits = 0;
         if (pos == TOTAL) begin
            m_valid = (hits >= P_MIN_ACT);
            if (m_valid) begin m_iter = (m_iter + 1) % 65536; m_fail = 0; end
            else m_fail++;
         end
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_on) begin
         chk("adapt", 32'(dpd_adapt), 32'(pos > P_SETTLE && pos <= P_SETTLE + P_WINDOW));
         chk("busy",  32'(busy),      32'(pos != 0));
         chk("done",  32'(done),      32'(pos == TOTAL));
         chk("valid", 32'(valid),     32'(m_valid));
         chk("iter",  32'(iter_cnt),  m_iter);
         chk("fault", 32'(fault),     32'(m_fault));
      end
   end

   int first_ad, last_ad, n_done;
   int done_at[$];
   bit busy_hist[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int first_done();
      return (done_at.size() > 0) ? done_at[0] : -1;
   endfunction

   // Cycle 0 is the cycle in which the caller drove start/cont.
   task automatic observe(input int n, input int abort_cyc, input int pulse_cyc,
                          input int drop_cont_at, input int hit_lo, input int hit_hi);
      first_ad = -1; last_ad = -1; n_done = 0;
      done_at.delete(); busy_hist.delete();
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         if (dpd_adapt === 1'b1) begin
            if (first_ad < 0) first_ad = k;
            last_ad = k;
         end
         if (done === 1'b1) begin n_done++; done_at.push_back(k); end
         busy_hist.push_back(busy === 1'b1);
         tick();
         start = (k + 1 == pulse_cyc);
         if (k + 1 == abort_cyc) enable = 1'b0;
         if (drop_cont_at > 0 && n_done == drop_cont_at) cont = 1'b0;
         if (hit_lo >= 0) magn = (k + 1 >= hit_lo && k + 1 <= hit_hi) ? HI : LO;
      end
   endtask

   initial begin
      int low;
      reset_b = 1'b0;
      tick(); tick();
      chk_on = 1'b1;
      tick();
      chk("rst_adapt", 32'(dpd_adapt), 0);
      chk("rst_busy",  32'(busy), 0);
      chk("rst_done",  32'(done), 0);
      chk("rst_valid", 32'(valid), 0);
      chk("rst_iter",  32'(iter_cnt), 0);
      chk("rst_fault", 32'(fault), 0);

      reset_b = 1'b1; enable = 1'b1; mag_thr = THR; magn = HI;
      repeat (3) tick();

      // Single accepted iteration.
      start = 1'b1;
      observe(20, -1, -1, 0, -1, -1);
      chk("s1_first_adapt", 32'(first_ad), 5);
      chk("s1_last_adapt",  32'(last_ad), 12);
      chk("s1_n_done",      32'(n_done), 1);
      chk("s1_done_cyc",    32'(first_done()), 15);
      chk("s1_valid",       32'(valid), 1);
      chk("s1_iter",        32'(iter_cnt), 1);
      chk("s1_model_iter",  m_iter, 1);
      chk("s1_idle_busy",   32'(busy), 0);

      // Low signal for the whole window.
      magn = LO; start = 1'b1;
      observe(20, -1, -1, 0, -1, -1);
      chk("low_done_cyc", 32'(first_done()), 15);
      chk("low_valid",    32'(valid), 0);
      chk("low_iter",     32'(iter_cnt), 1);

      // magn equal to threshold counts as active.
      magn = THR; start = 1'b1;
      observe(20, -1, -1, 0, -1, -1);
      chk("eq_valid", 32'(valid), 1);
      chk("eq_iter",  32'(iter_cnt), 2);

      // Exactly MIN_ACT hits, the last one in the final capture cycle.
      magn = LO; start = 1'b1;
      observe(20, -1, -1, 0, 8, 12);
      chk("min5_valid", 32'(valid), 1);
      chk("min5_iter",  32'(iter_cnt), 3);

      // One hit short of MIN_ACT.
      magn = LO; start = 1'b1;
      observe(20, -1, -1, 0, 5, 8);
      chk("min4_valid", 32'(valid), 0);
      chk("min4_iter",  32'(iter_cnt), 3);

      // Continuous mode: three back-to-back iterations.
      magn = HI; cont = 1'b1;
      observe(50, -1, -1, 2, -1, -1);
      chk("cont_n_done", 32'(n_done), 3);
      chk("cont_done0",  32'(first_done()), 15);
      chk("cont_done1",  32'((done_at.size() > 1) ? done_at[1] : -1), 30);
      chk("cont_done2",  32'((done_at.size() > 2) ? done_at[2] : -1), 45);
      low = 0;
      for (int k = 1; k <= 45; k++) if (!busy_hist[k]) low++;
      chk("cont_busy_low", 32'(low), 0);
      chk("cont_iter",     32'(iter_cnt), 6);
      chk("cont_after",    32'(busy_hist[47]), 0);

      // Abort in the third capture cycle.
      start = 1'b1;
      observe(25, 7, -1, 0, -1, -1);
      chk("abort_last_adapt", 32'(last_ad), 7);
      chk("abort_busy",       32'(busy_hist[8]), 0);
      chk("abort_n_done",     32'(n_done), 0);
      chk("abort_iter",       32'(iter_cnt), 6);
      chk("abort_valid",      32'(valid), 1);
      enable = 1'b1;
      tick();

      // Start pulse during HOLD is dropped.
      start = 1'b1;
      observe(35, -1, 14, 0, -1, -1);
      chk("hold_n_done", 32'(n_done), 1);
      chk("hold_busy20", 32'(busy_hist[20]), 0);
      chk("hold_iter",   32'(iter_cnt), 7);

      // Reset asserted during SETTLE clears outputs at once.
      start = 1'b1;
      tick(); start = 1'b0;
      tick(); tick();
      reset_b = 1'b0;
      #1;
      chk("arst_busy",  32'(busy), 0);
      chk("arst_valid", 32'(valid), 0);
      chk("arst_iter",  32'(iter_cnt), 0);
      chk("arst_done",  32'(done), 0);
      tick();
      reset_b = 1'b1;
      tick();

`ifdef DPD_ADAPT_CTRL_WDT_EN
      // Two discarded iterations in continuous mode trip the watchdog.
      magn = LO; cont = 1'b1;
      observe(40, -1, -1, 0, -1, -1);
      chk("wdt_fault", 32'(fault), 1);
      chk("wdt_busy",  32'(busy), 0);
      chk("wdt_n_done", 32'(n_done), 2);
      cont = 1'b0; enable = 1'b0;
      tick(); tick();
      enable = 1'b1;
      tick();
      chk("wdt_clear", 32'(fault), 0);
`endif

      // Randomized traffic checked by the model.
      cont = 1'b0; start = 1'b0; mag_thr = 20'd512;
      for (int c = 0; c < 3000; c++) begin
         tick();
         enable  = ($urandom_range(0, 99) < 97);
         start   = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 63) == 0) cont = ~cont;
         magn    = ($urandom_range(0, 9) == 0) ? mag_thr : 20'($urandom_range(0, 1023));
         reset_b = ($urandom_range(0, 999) != 0);
      end
      tick();
      reset_b = 1'b1;
      repeat (3) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
